// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings for the snake direction controller
//
// Purpose: heading encoding, turn codes and the default debounce length used by
//          snake_direction_ctrl and snake_button_debounce.
// Ports:   none (package).
package snake_pkg;

  // Heading encoding; a right turn is +1 mod 4, a left turn is -1 mod 4.
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  // 10 ms at 25 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_RIGHT = 2'd1,
    TURN_LEFT  = 2'd2
  } turn_e;

  // Relative 90-degree turn; wrap-around comes from 2-bit overflow.
  function automatic logic [1:0] apply_turn(input logic [1:0] dir, input turn_e turn);
    case (turn)
      TURN_RIGHT: apply_turn = dir + 2'd1;
      TURN_LEFT:  apply_turn = dir - 2'd1;
      default:    apply_turn = dir;
    endcase
  endfunction

endpackage

// File: rtl/snake_direction_ctrl_if.sv
// rtl/snake_direction_ctrl_if.sv - button/heading bundle of the snake direction controller
//
// Purpose: groups the game-side inputs and heading outputs of snake_direction_ctrl.
// Signals: right_P, left_P   raw buttons (async to the clock)
//          game_tik, start   move pulse / game running
//          right_sync, left_sync          synchronised buttons
//          right_register, left_register  pending turn (queue head)
//          right, down, left, up          one-hot heading
//          turn_applied                   heading changed on the previous tik
// Modports: master drives the inputs (game side / bench), slave is the controller.
interface snake_direction_ctrl_if;
  logic right_P;
  logic left_P;
  logic game_tik;
  logic start;
  logic right_sync;
  logic left_sync;
  logic right_register;
  logic left_register;
  logic right;
  logic down;
  logic left;
  logic up;
  logic turn_applied;

  modport master (
    output right_P, left_P, game_tik, start,
    input  right_sync, left_sync, right_register, left_register,
    input  right, down, left, up, turn_applied
  );

  modport slave (
    input  right_P, left_P, game_tik, start,
    output right_sync, left_sync, right_register, left_register,
    output right, down, left, up, turn_applied
  );
endinterface

// File: rtl/snake_button_debounce.sv
// rtl/snake_button_debounce.sv - 2-flop synchroniser, debounce counter and press detect
//
// Purpose: conditions one raw push-button into a one-cycle press pulse.
// Ports:   clk      system clock
//          rst      asynchronous active-high reset
//          i_btn    raw button, asynchronous to clk
//          o_sync   button after the 2nd synchroniser flop
//          o_press  one-cycle pulse on an accepted 0->1 change of the stable state
module snake_button_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_sync,
  output logic o_press
);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = r_sync ^ r_stable;
  // Last counted cycle of disagreement: the stable state flips on this edge.
  assign w_accept = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync  = r_sync;
  // Press is flagged in the cycle the stable state is about to rise, so the
  // pending turn lands on the same edge the stable state changes.
  assign o_press = w_accept & r_sync;

endmodule

// File: rtl/snake_direction_ctrl.sv
// rtl/snake_direction_ctrl.sv - button conditioning and heading register of the snake game
//
// Purpose: debounces right_P/left_P, holds turn requests until game_tik and
//          applies them as relative 90-degree turns to the snake heading.
// Ports:   clock_25  25 MHz clock
//          reset     asynchronous active-high reset
//          io_if     snake_direction_ctrl_if.slave (buttons, game_tik, start,
//                    sync/pending status, one-hot heading, turn_applied)
// Config:  TURN_QUEUE_EN defined   -> 2-entry turn FIFO (0=right, 1=left)
//          TURN_QUEUE_EN undefined -> single pending turn, newest press wins
module snake_direction_ctrl
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int         CNT_W           = 18,
  parameter logic [1:0] INIT_DIR        = DIR_RIGHT
) (
  input  logic                   clock_25,
  input  logic                   reset,
  snake_direction_ctrl_if.slave  io_if
);

  logic w_press_r;
  logic w_press_l;
  logic w_take_r;
  logic w_take_l;
  logic w_tik;
  turn_e w_head;

  snake_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk     (clock_25),
    .rst     (reset),
    .i_btn   (io_if.right_P),
    .o_sync  (io_if.right_sync),
    .o_press (w_press_r)
  );

  snake_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk     (clock_25),
    .rst     (reset),
    .i_btn   (io_if.left_P),
    .o_sync  (io_if.left_sync),
    .o_press (w_press_l)
  );

  // Ambiguous double press and presses outside a game are discarded.
  assign w_take_r = w_press_r & ~w_press_l & io_if.start;
  assign w_take_l = w_press_l & ~w_press_r & io_if.start;
  assign w_tik    = io_if.game_tik & io_if.start;

`ifdef TURN_QUEUE_EN
  logic       r_q0;
  logic       r_q1;
  logic [1:0] r_qcnt;
  logic       w_q0_nxt;
  logic       w_q1_nxt;
  logic [1:0] w_qcnt_nxt;
  logic       w_pop;
  logic       w_push;

  assign w_push = w_take_r | w_take_l;
  assign w_pop  = w_tik && (r_qcnt != 2'd0);
  assign w_head = (r_qcnt == 2'd0) ? TURN_NONE : (r_q0 ? TURN_LEFT : TURN_RIGHT);

  always_comb begin
    w_q0_nxt   = r_q0;
    w_q1_nxt   = r_q1;
    w_qcnt_nxt = r_qcnt;
    if (!io_if.start) begin
      w_qcnt_nxt = 2'd0;
    end else begin
      case ({w_pop, w_push})
        2'b10: begin
          w_q0_nxt   = r_q1;
          w_qcnt_nxt = r_qcnt - 2'd1;
        end
        2'b01: begin
          if (r_qcnt == 2'd0) begin
            w_q0_nxt   = w_take_l;
            w_qcnt_nxt = 2'd1;
          end else if (r_qcnt == 2'd1) begin
            w_q1_nxt   = w_take_l;
            w_qcnt_nxt = 2'd2;
          end
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged.
          if (r_qcnt == 2'd1) begin
            w_q0_nxt = w_take_l;
          end else begin
            w_q0_nxt = r_q1;
            w_q1_nxt = w_take_l;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_q0   <= 1'b0;
      r_q1   <= 1'b0;
      r_qcnt <= 2'd0;
    end else begin
      r_q0   <= w_q0_nxt;
      r_q1   <= w_q1_nxt;
      r_qcnt <= w_qcnt_nxt;
    end
  end
`else
  turn_e r_pend;
  turn_e w_pend_nxt;

  assign w_head = r_pend;

  // A press in the tik cycle overwrites the slot the tik is consuming, so it
  // survives for the following tik.
  always_comb begin
    w_pend_nxt = r_pend;
    if (!io_if.start) begin
      w_pend_nxt = TURN_NONE;
    end else if (w_take_r) begin
      w_pend_nxt = TURN_RIGHT;
    end else if (w_take_l) begin
      w_pend_nxt = TURN_LEFT;
    end else if (w_tik) begin
      w_pend_nxt = TURN_NONE;
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_pend <= TURN_NONE;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end
`endif

  logic [1:0] r_dir;
  logic [1:0] w_dir_nxt;
  logic       r_applied;
  logic       w_applied_nxt;

  always_comb begin
    w_dir_nxt     = r_dir;
    w_applied_nxt = 1'b0;
    if (!io_if.start) begin
      w_dir_nxt = INIT_DIR;
    end else if (w_tik && (w_head != TURN_NONE)) begin
      w_dir_nxt     = apply_turn(r_dir, w_head);
      w_applied_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_dir     <= INIT_DIR;
      r_applied <= 1'b0;
    end else begin
      r_dir     <= w_dir_nxt;
      r_applied <= w_applied_nxt;
    end
  end

  assign io_if.right          = (r_dir == DIR_RIGHT);
  assign io_if.down           = (r_dir == DIR_DOWN);
  assign io_if.left           = (r_dir == DIR_LEFT);
  assign io_if.up             = (r_dir == DIR_UP);
  assign io_if.turn_applied   = r_applied;
  assign io_if.right_register = (w_head == TURN_RIGHT);
  assign io_if.left_register  = (w_head == TURN_LEFT);

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// tb/tb_snake_direction_ctrl.sv - scoreboard bench for snake_direction_ctrl
module tb_snake_direction_ctrl;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_direction_ctrl_if bus ();

  snake_direction_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .INIT_DIR        (DIR_RIGHT)
  ) dut (
    .clock_25 (clk),
    .reset    (rst),
    .io_if    (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];

  // {up,left,down,right}
  function automatic logic [3:0] onehot(input logic [1:0] d);
    case (d)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      default: onehot = 4'b1000;
    endcase
  endfunction

  function automatic logic [3:0] heading();
    heading = {bus.up, bus.left, bus.down, bus.right};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full press: 8 clocks held, 8 clocks released (release fully debounced).
  task automatic press(input bit is_left);
    if (is_left) bus.left_P = 1'b1; else bus.right_P = 1'b1;
    ticks(8);
    bus.left_P  = 1'b0;
    bus.right_P = 1'b0;
    ticks(8);
  endtask

  // One game tik; exp_valid pushes the heading expected after it.
  task automatic tik(input bit exp_valid, input logic [1:0] exp_dir);
    if (exp_valid) exp_q.push_back(exp_dir);
    bus.game_tik = 1'b1;
    tick();
    bus.game_tik = 1'b0;
    ticks(2);
  endtask

  // Monitor: every turn_applied pulse must match the next queued heading.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst && bus.turn_applied) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL turn_applied: unexpected pulse, heading %b, expected no pulse", heading());
      end else begin
        e = exp_q.pop_front();
        if (heading() !== onehot(e)) begin
          n_err++;
          $display("FAIL turn_heading: got %b, expected %b", heading(), onehot(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.right_P  = 1'b0;
    bus.left_P   = 1'b0;
    bus.game_tik = 1'b0;
    bus.start    = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();
    chk("reset_heading", heading(), 4'b0001);
    chk("reset_rreg", bus.right_register, 1'b0);
    chk("reset_lreg", bus.left_register, 1'b0);
    chk("reset_applied", bus.turn_applied, 1'b0);

    bus.start = 1'b1;
    ticks(2);

    // Too-short press: 3 clocks high.
    bus.right_P = 1'b1;
    ticks(3);
    bus.right_P = 1'b0;
    ticks(10);
    chk("short_press_rreg", bus.right_register, 1'b0);

    // Valid press: sync lags 2, pending at 2+4.
    bus.right_P = 1'b1;
    tick();
    chk("sync_lag1", bus.right_sync, 1'b0);
    tick();
    chk("sync_lag2", bus.right_sync, 1'b1);
    ticks(3);
    chk("press_at5", bus.right_register, 1'b0);
    tick();
    chk("press_at6", bus.right_register, 1'b1);
    ticks(2);
    bus.right_P = 1'b0;
    ticks(8);
    chk("press_held_pending", bus.right_register, 1'b1);
    chk("press_lreg", bus.left_register, 1'b0);
    tik(1'b1, DIR_DOWN);
    chk("tik_consumed", bus.right_register, 1'b0);
    chk("heading_down", heading(), 4'b0010);

    // Bounce 1-0-1 then held: a single press.
    bus.right_P = 1'b1; tick();
    bus.right_P = 1'b0; tick();
    bus.right_P = 1'b1; ticks(8);
    bus.right_P = 1'b0; ticks(10);
    chk("bounce_pending", bus.right_register, 1'b1);
    tik(1'b1, DIR_LEFT);
    chk("bounce_single", bus.right_register, 1'b0);

    // Right turns: L->U->R, then D,L,U,R.
    press(1'b0); tik(1'b1, DIR_UP);
    press(1'b0); tik(1'b1, DIR_RIGHT);
    press(1'b0); tik(1'b1, DIR_DOWN);
    press(1'b0); tik(1'b1, DIR_LEFT);
    press(1'b0); tik(1'b1, DIR_UP);
    press(1'b0); tik(1'b1, DIR_RIGHT);
    chk("right_wrap", heading(), 4'b0001);

    // Left turns: R->U->L->D->R.
    press(1'b1); tik(1'b1, DIR_UP);
    chk("left_from_right", heading(), 4'b1000);
    press(1'b1); tik(1'b1, DIR_LEFT);
    press(1'b1); tik(1'b1, DIR_DOWN);
    press(1'b1); tik(1'b1, DIR_RIGHT);

    // Simultaneous right+left: dropped.
    bus.right_P = 1'b1;
    bus.left_P  = 1'b1;
    ticks(8);
    bus.right_P = 1'b0;
    bus.left_P  = 1'b0;
    ticks(8);
    chk("simul_rreg", bus.right_register, 1'b0);
    chk("simul_lreg", bus.left_register, 1'b0);
    tik(1'b0, DIR_RIGHT);
    chk("simul_heading", heading(), 4'b0001);

    // Left press coincident with a tik consuming a pending right.
    press(1'b0);
    bus.left_P = 1'b1;
    ticks(5);
    exp_q.push_back(DIR_DOWN);
    bus.game_tik = 1'b1;
    tick();
    bus.game_tik = 1'b0;
    chk("coincident_lreg", bus.left_register, 1'b1);
    chk("coincident_rreg", bus.right_register, 1'b0);
    ticks(2);
    bus.left_P = 1'b0;
    ticks(8);
    tik(1'b1, DIR_RIGHT);

`ifdef TURN_QUEUE_EN
    press(1'b0); press(1'b0);
    tik(1'b1, DIR_DOWN);
    chk("queue_second", bus.right_register, 1'b1);
    tik(1'b1, DIR_LEFT);
    chk("queue_empty", bus.right_register, 1'b0);
    press(1'b0); press(1'b1);
    tik(1'b1, DIR_UP);
    chk("queue_left_head", bus.left_register, 1'b1);
    tik(1'b1, DIR_LEFT);
    press(1'b0); press(1'b0); press(1'b1);
    tik(1'b1, DIR_UP);
    tik(1'b1, DIR_RIGHT);
    chk("queue_full_drop", bus.left_register, 1'b0);
    tik(1'b0, DIR_RIGHT);
`else
    press(1'b0); press(1'b0);
    tik(1'b1, DIR_DOWN);
    chk("single_slot", bus.right_register, 1'b0);
    tik(1'b0, DIR_DOWN);
    press(1'b0); press(1'b1);
    chk("overwrite_lreg", bus.left_register, 1'b1);
    chk("overwrite_rreg", bus.right_register, 1'b0);
    tik(1'b1, DIR_RIGHT);
`endif
    chk("queue_end_heading", heading(), 4'b0001);

    // start deassert with a turn pending.
    press(1'b0); tik(1'b1, DIR_DOWN);
    press(1'b0);
    chk("stop_pending", bus.right_register, 1'b1);
    bus.start = 1'b0;
    tick();
    chk("stop_rreg", bus.right_register, 1'b0);
    chk("stop_heading", heading(), 4'b0001);
    press(1'b0);
    chk("stopped_press", bus.right_register, 1'b0);
    bus.start = 1'b1;
    tick();
    tik(1'b0, DIR_RIGHT);
    chk("restart_heading", heading(), 4'b0001);

    // Reset mid-debounce with a turn pending and heading != R.
    press(1'b0); tik(1'b1, DIR_DOWN);
    press(1'b0);
    bus.right_P = 1'b1;
    ticks(3);
    #3;
    rst = 1'b1;
    #1;
    chk("midreset_heading", heading(), 4'b0001);
    chk("midreset_rreg", bus.right_register, 1'b0);
    chk("midreset_applied", bus.turn_applied, 1'b0);
    chk("midreset_sync", bus.right_sync, 1'b0);
    ticks(2);
    rst = 1'b0;
    ticks(5);
    chk("held_thru_reset_5", bus.right_register, 1'b0);
    tick();
    chk("held_thru_reset_6", bus.right_register, 1'b1);
    bus.right_P = 1'b0;
    ticks(8);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
